// File: rtl/multiplier_mac_pipe.sv
// -----------------------------------------------------------------------------
// multiplier_mac_pipe
//
// Shared MUL/MAC functional unit. It is fully pipelined and accepts one
// operation per cycle. The WIDTH x WIDTH product is formed in the issue cycle
// and extended to ACC_WIDTH bits: sign-extended for signed operands,
// zero-extended for unsigned ones. The product then passes through LATENCY-1
// register stages. The final stage applies the operation against the internal
// accumulator and registers the result.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in0/in1    multiplicand / multiplier (WIDTH bits)
//   signed_in  1: two's-complement operands, 0: unsigned
//   op         00 MUL, 01 MAC, 10 LOAD (acc := product), 11 same as MUL
//   valid_in   operands and op valid this cycle
//   out        result (ACC_WIDTH bits); holds its value between valid results
//   valid_out  out carries a new result this cycle
//   overflow   sticky MAC overflow flag, present only when
//              MULTIPLIER_MAC_OVERFLOW_EN is defined
//
// Optional feature macro: MULTIPLIER_MAC_OVERFLOW_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module multiplier_mac_pipe #(
    parameter int WIDTH     = 16,
    parameter int LATENCY   = 2,
    parameter int ACC_WIDTH = 2*WIDTH+8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    input  logic                 signed_in,
    input  logic [1:0]           op,
    input  logic                 valid_in,
    output logic [ACC_WIDTH-1:0] out,
    output logic                 valid_out
`ifdef MULTIPLIER_MAC_OVERFLOW_EN
    ,
    output logic                 overflow
`endif
);

    localparam int PW = 2*WIDTH;

    typedef enum logic [1:0] {
        OP_MUL     = 2'b00,
        OP_MAC     = 2'b01,
        OP_LOAD    = 2'b10,
        OP_MUL_ALT = 2'b11
    } op_e;

    // One pipeline slot: the extended product plus the control that travels
    // with it to the final stage.
    typedef struct packed {
        logic                 valid;
`ifdef MULTIPLIER_MAC_OVERFLOW_EN
        logic                 sgn;
`endif
        op_e                  op;
        logic [ACC_WIDTH-1:0] prod;
    } stage_t;

    // ---------------------------------------------------------------------
    // Issue stage: full-width product, extended to the accumulator width
    // ---------------------------------------------------------------------
    logic signed [PW-1:0] prod_s;
    logic        [PW-1:0] prod_u;
    stage_t               s0;
    stage_t               fin;

    assign prod_s = PW'($signed(in0)) * PW'($signed(in1));
    assign prod_u = PW'(in0) * PW'(in1);

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        s0       = '0;
        s0.valid = valid_in;
        s0.op    = op_e'(op);
`ifdef MULTIPLIER_MAC_OVERFLOW_EN
        s0.sgn   = signed_in;
`endif
        if (signed_in) begin
            s0.prod = ACC_WIDTH'(prod_s);   // signed source: sign-extends
        end else begin
            s0.prod = ACC_WIDTH'(prod_u);
        end
    end

    // ---------------------------------------------------------------------
    // Intermediate register stages (none when LATENCY == 1)
    // ---------------------------------------------------------------------
    generate
        if (LATENCY == 1) begin : g_comb
            assign fin = s0;
        end else begin : g_pipe
            stage_t pipe_q [LATENCY-1];

            // NOTE: state is updated with non-blocking assignments so every
            // stage samples the value its predecessor held before this edge.
            // NOTE: the whole stage array is reset, not just the valid bits.
            // This keeps the datapath free of X after reset. In-flight
            // operations are dropped because their valid bits clear.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < LATENCY-1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= s0;
                    for (int i = 1; i < LATENCY-1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign fin = pipe_q[LATENCY-2];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Final stage: apply op against the accumulator, register the result
    // ---------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] out_q, out_d;
    logic                 valid_q;
    logic [ACC_WIDTH-1:0] sum;
    logic                 ovf_q, ovf_d;

`ifdef MULTIPLIER_MAC_OVERFLOW_EN
    logic                 carry;
    logic                 mac_ovf;

    assign {carry, sum} = {1'b0, acc_q} + {1'b0, fin.prod};

    // Signed overflow: both addends share a sign and the sum's sign differs.
    // Unsigned overflow: carry out of the top bit.
    assign mac_ovf = fin.sgn
                   ? ((acc_q[ACC_WIDTH-1] == fin.prod[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1]   != acc_q[ACC_WIDTH-1]))
                   : carry;
`else
    // Plain modulo-2^ACC_WIDTH addition; the carry is dropped.
    assign sum = acc_q + fin.prod;
`endif

    always_comb begin
        acc_d = acc_q;
        out_d = out_q;
        ovf_d = ovf_q;
        if (fin.valid) begin
            case (fin.op)
                OP_MAC: begin
                    acc_d = sum;
                    out_d = sum;
`ifdef MULTIPLIER_MAC_OVERFLOW_EN
                    ovf_d = ovf_q | mac_ovf;
`endif
                end
                OP_LOAD: begin
                    acc_d = fin.prod;
                    out_d = fin.prod;
                    ovf_d = 1'b0;
                end
                default: begin
                    // MUL and its alias leave the accumulator untouched.
                    out_d = fin.prod;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= fin.valid;
            ovf_q   <= ovf_d;
        end
    end

    assign out       = out_q;
    assign valid_out = valid_q;

`ifdef MULTIPLIER_MAC_OVERFLOW_EN
    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_multiplier_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_multiplier_mac_pipe
//
// Testbench for multiplier_mac_pipe. It uses three instances:
//   unit 0: default parameters (WIDTH 16, LATENCY 2, ACC 40)
//   unit 1: WIDTH 8, LATENCY 1 (ACC 24)
//   unit 2: WIDTH 8, LATENCY 4 (ACC 24)
// The bench computes each expected result when the operation is driven,
// together with the cycle in which the result must appear, and queues it per
// unit. A monitor on the falling edge pops and compares the queue whenever
// valid_out is high. While valid_out is low, the monitor checks that out holds
// its last value.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_multiplier_mac_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] in0, in1;
    logic        signed_in;
    logic [1:0]  op_in;
    logic        vld_main, vld_w8;

    logic [39:0] out_main;
    logic [23:0] out_l1, out_l4;
    logic        vo_main, vo_l1, vo_l4;
    logic        ovf_main, ovf_l1, ovf_l4;

    always #5 clock = ~clock;

    multiplier_mac_pipe u_main (
        .clock(clock), .reset_n(reset_n), .in0(in0), .in1(in1),
        .signed_in(signed_in), .op(op_in), .valid_in(vld_main),
        .out(out_main), .valid_out(vo_main)
`ifdef MULTIPLIER_MAC_OVERFLOW_EN
        , .overflow(ovf_main)
`endif
    );

    multiplier_mac_pipe #(.WIDTH(8), .LATENCY(1)) u_l1 (
        .clock(clock), .reset_n(reset_n), .in0(in0[7:0]), .in1(in1[7:0]),
        .signed_in(signed_in), .op(op_in), .valid_in(vld_w8),
        .out(out_l1), .valid_out(vo_l1)
`ifdef MULTIPLIER_MAC_OVERFLOW_EN
        , .overflow(ovf_l1)
`endif
    );

    multiplier_mac_pipe #(.WIDTH(8), .LATENCY(4)) u_l4 (
        .clock(clock), .reset_n(reset_n), .in0(in0[7:0]), .in1(in1[7:0]),
        .signed_in(signed_in), .op(op_in), .valid_in(vld_w8),
        .out(out_l4), .valid_out(vo_l4)
`ifdef MULTIPLIER_MAC_OVERFLOW_EN
        , .overflow(ovf_l4)
`endif
    );

`ifndef MULTIPLIER_MAC_OVERFLOW_EN
    assign ovf_main = 1'b0;
    assign ovf_l1   = 1'b0;
    assign ovf_l4   = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Bookkeeping
    // ---------------------------------------------------------------------
    typedef struct {
        logic [63:0] out;
        logic        ovf;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        vld;
        logic [15:0] a;
        logic [15:0] b;
        logic        sgn;
        logic [1:0]  op;
        logic [39:0] exp;
    } vec_t;

    exp_t        sb [3][$];
    logic [63:0] acc_m    [3];
    logic        ovf_m    [3];
    logic [63:0] last_out [3];
    vec_t        vecs     [16];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int lat_of(input int u);
        case (u)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one operation on unit u; updates that unit's
    // accumulator and overflow state, returns the out value and flag.
    function automatic void model(input int u, input logic [15:0] a, input logic [15:0] b,
                                  input logic sgn, input logic [1:0] opc,
                                  output logic [63:0] res, output logic ovf);
        int          w;
        int          aw;
        logic [63:0] mask, am, bm, prod, sum;
        longint      sa, sbv;
        logic        c;
        w    = (u == 0) ? 16 : 8;
        aw   = (u == 0) ? 40 : 24;
        mask = (64'd1 << aw) - 64'd1;
        am   = 64'(a) & ((64'd1 << w) - 64'd1);
        bm   = 64'(b) & ((64'd1 << w) - 64'd1);
        if (sgn) begin
            sa   = $signed(am << (64 - w)) >>> (64 - w);
            sbv  = $signed(bm << (64 - w)) >>> (64 - w);
            prod = 64'(sa * sbv) & mask;
        end else begin
            prod = (am * bm) & mask;
        end
        res = prod;
        case (opc)
            2'b01: begin
                sum = acc_m[u] + prod;
                res = sum & mask;
                if (sgn) c = (acc_m[u][aw-1] == prod[aw-1]) && (res[aw-1] != acc_m[u][aw-1]);
                else     c = sum[aw];
                ovf_m[u] = ovf_m[u] | c;
                acc_m[u] = res;
            end
            2'b10: begin
                acc_m[u] = prod;
                ovf_m[u] = 1'b0;
            end
            default: ;
        endcase
        ovf = ovf_m[u];
    endfunction

    // Drive one cycle of stimulus and queue the results it must produce.
    task automatic issue(input logic vm, input logic vw, input logic [15:0] a, input logic [15:0] b,
                         input logic sgn, input logic [1:0] opc,
                         input logic use_exp, input logic [39:0] exp_main);
        exp_t        e;
        logic [63:0] r;
        logic        o;
        @(negedge clock);
        in0       = a;
        in1       = b;
        signed_in = sgn;
        op_in     = opc;
        vld_main  = vm;
        vld_w8    = vw;
        for (int u = 0; u < 3; u++) begin
            if ((u == 0 && vm) || (u > 0 && vw)) begin
                model(u, a, b, sgn, opc, r, o);
                e.out = (u == 0 && use_exp) ? 64'(exp_main) : r;
                e.ovf = o;
                e.cyc = cyc + lat_of(u);
                sb[u].push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            issue(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom), 1'b0, '0);
        end
    endtask

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    task automatic mon(input int u, input logic v, input logic [63:0] o, input logic ov);
        exp_t e;
        if (v) begin
            if (sb[u].size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid u%0d: got valid_out=1 out=%0h, expected valid_out=0", u, o);
            end else begin
                e = sb[u].pop_front();
                check($sformatf("u%0d_out", u), o, e.out);
                check($sformatf("u%0d_latency_cycle", u), 64'(cyc), 64'(e.cyc));
`ifdef MULTIPLIER_MAC_OVERFLOW_EN
                check($sformatf("u%0d_overflow", u), 64'(ov), 64'(e.ovf));
`endif
            end
            last_out[u] = o;
        end else begin
            check($sformatf("u%0d_hold", u), o, last_out[u]);
            if (sb[u].size() > 0 && sb[u][0].cyc <= cyc) begin
                e = sb[u].pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_valid u%0d: got valid_out=0, expected out=%0h at cycle %0d",
                         u, e.out, e.cyc);
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, vo_main, 64'(out_main), ovf_main);
        mon(1, vo_l1,   64'(out_l1),   ovf_l1);
        mon(2, vo_l4,   64'(out_l4),   ovf_l4);
    end

    task automatic clear_model();
        for (int u = 0; u < 3; u++) begin
            sb[u].delete();
            acc_m[u]    = '0;
            ovf_m[u]    = 1'b0;
            last_out[u] = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        reset_n   = 1'b0;
        in0       = '0;
        in1       = '0;
        signed_in = 1'b0;
        op_in     = 2'b00;
        vld_main  = 1'b0;
        vld_w8    = 1'b0;
        clear_model();

        //            vld   a         b         sgn   op     expected out
        vecs[0]  = '{1'b1, 16'd3,    16'd5,    1'b0, 2'b00, 40'd15};
        vecs[1]  = '{1'b1, 16'hFFFF, 16'd2,    1'b1, 2'b00, 40'hFF_FFFF_FFFE};
        vecs[2]  = '{1'b1, 16'hFFFF, 16'd2,    1'b0, 2'b00, 40'd131070};
        vecs[3]  = '{1'b1, 16'd2,    16'd3,    1'b0, 2'b10, 40'd6};
        vecs[4]  = '{1'b1, 16'd4,    16'd5,    1'b0, 2'b01, 40'd26};
        vecs[5]  = '{1'b1, 16'd1,    16'd1,    1'b0, 2'b01, 40'd27};
        vecs[6]  = '{1'b1, 16'd10,   16'd1,    1'b0, 2'b10, 40'd10};
        vecs[7]  = '{1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 2'b10, 40'd0};
        vecs[8]  = '{1'b1, 16'd7,    16'd7,    1'b0, 2'b00, 40'd49};
        vecs[9]  = '{1'b0, 16'h1234, 16'h5678, 1'b0, 2'b01, 40'd0};
        vecs[10] = '{1'b1, 16'd2,    16'd2,    1'b0, 2'b01, 40'd14};
        vecs[11] = '{1'b1, 16'd3,    16'd3,    1'b0, 2'b11, 40'd9};
        vecs[12] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 2'b01, 40'd15};
        vecs[13] = '{1'b1, 16'h8000, 16'h7FFF, 1'b1, 2'b01, 40'hFF_C000_800F};
        vecs[14] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 2'b01, 40'h00_BFFE_8010};
        vecs[15] = '{1'b1, 16'h8000, 16'h8000, 1'b1, 2'b10, 40'h00_4000_0000};

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        check("reset_out",       64'(out_main), 64'd0);
        check("reset_valid_out", 64'(vo_main),  64'd0);
        check("reset_out_l4",    64'(out_l4),   64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed vectors, issued back to back
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].vld, 1'b0, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].op,
                  1'b1, vecs[i].exp);
        end
        idle(8);

        // Reset while a MAC is in flight: the MAC must never appear
        @(negedge clock);
        in0 = 16'd9; in1 = 16'd9; signed_in = 1'b0; op_in = 2'b01; vld_main = 1'b1; vld_w8 = 1'b0;
        @(negedge clock);
        vld_main = 1'b0;
        #2;
        reset_n = 1'b0;
        clear_model();
        #1;
        check("midreset_out",       64'(out_main), 64'd0);
        check("midreset_valid_out", 64'(vo_main),  64'd0);
        repeat (3) @(negedge clock);
        #1;
        check("midreset_out_held", 64'(out_main), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        issue(1'b1, 1'b0, 16'd1, 16'd1, 1'b0, 2'b01, 1'b1, 40'd1);
        idle(8);

        // Random operations on all three units, with occasional bubbles
        for (int i = 0; i < 50; i++) begin
            logic v;
            v = ($urandom_range(0, 4) != 0);
            issue(v, v, 16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom), 1'b0, '0);
        end
        idle(8);

        // Unsigned 255x255 MACs until the 24-bit accumulator wraps, then LOAD
        issue(1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 2'b10, 1'b0, '0);
        for (int i = 0; i < 260; i++) begin
            issue(1'b0, 1'b1, 16'd255, 16'd255, 1'b0, 2'b01, 1'b0, '0);
        end
        issue(1'b0, 1'b1, 16'd3, 16'd4, 1'b0, 2'b10, 1'b0, '0);
        issue(1'b0, 1'b1, 16'd1, 16'd1, 1'b0, 2'b01, 1'b0, '0);
        idle(8);

        // Every queued result must have been produced
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d_pending_results", u), 64'(sb[u].size()), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
